// File: rtl/multiword_add_seq_pkg.sv
// Shared types and defaults for the slice-serial multiword adder.
// Optional subtract support is enabled by MULTIWORD_ADD_SEQ_SUB_EN.
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_DEFAULT = 4;

endpackage

// File: rtl/multiword_add_seq_adder_slice.sv
// SLICE-bit ripple-carry adder used once per cycle by multiword_add_seq.
// Purely combinational; the carry chain is unrolled by the loop.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);

    logic w_c;

    always_comb begin
        w_c = i_cin;
        o_s = '0;
        for (int i = 0; i < W; i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Slice-serial WIDTH-bit adder: one SLICE-bit slice per cycle, IDLE/RUN/DONE.
// Define MULTIWORD_ADD_SEQ_SUB_EN to make the sub input select a-b.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sub;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic              w_in_sub;
    logic              w_accept;
    logic              w_last;
    logic [SLICE-1:0]  w_sl_a;
    logic [SLICE-1:0]  w_sl_b;
    logic [SLICE-1:0]  w_sl_s;
    logic              w_sl_co;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    assign w_in_sub = sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_in_sub     = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);

    // Subtraction is a + ~b + 1: invert b per slice, seed carry with 1
    assign w_sl_a = r_a[r_idx*SLICE +: SLICE];
    assign w_sl_b = r_b[r_idx*SLICE +: SLICE] ^ {SLICE{r_sub}};

    adder_slice #(
        .W (SLICE)
    ) u_slice (
        .i_a    (w_sl_a),
        .i_b    (w_sl_b),
        .i_cin  (r_carry),
        .o_s    (w_sl_s),
        .o_cout (w_sl_co)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= w_in_sub;
            r_carry <= w_in_sub;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum[r_idx*SLICE +: SLICE] <= w_sl_s;
            r_carry <= w_sl_co;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_sl_co;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
